fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the next-generation core. Owns the program
//  counter, issues reads to a synchronous instruction ROM, and buffers returned words with
//  their PCs in a DEPTH-entry queue. Decode consumes the queue over a valid/ready handshake.
//  Taken jumps flush the queue and squash in-flight reads; Halt drains fetch and raises Done.
// PARAMETERS
//  IW     9  instruction word width (bits)
//  AW     6  program-counter / ROM address width; PC space is 2**AW words
//  DEPTH  4  instruction queue entries; legal range is DEPTH >= 2
// PORTS
//  Clk          in   1        clock, rising edge
//  Reset        in   1        asynchronous, active-high; clears all state
//  Jen          in   1        redirect request (taken jump), single-cycle pulse
//  Jtarget      in   AW       redirect target address, sampled when Jen=1
//  Halt         in   1        stop fetching; sampled every cycle, latched internally
//  imem_en      out  1        ROM read strobe
//  imem_addr    out  AW       ROM read address
//  imem_data    in   IW       ROM read data, valid the cycle after imem_en=1
//  instr_valid  out  1        queue head holds a valid instruction
//  instr_ready  in   1        decode accepts the head this cycle
//  instr_data   out  IW       head instruction word
//  instr_pc     out  AW       address the head instruction was fetched from
//  count        out  $clog2(DEPTH+1)  current queue occupancy
//  Done         out  1        halt complete; sticky until Reset
// BEHAVIOUR
//  Reset: PC=0, queue empty, no read in flight, halt latch=0. Outputs imem_en=0,
//   imem_addr=0, instr_valid=0, instr_data=0, instr_pc=0, count=0, Done=0.
//  Issue: imem_en=1 when !halted && !Jen && (count + inflight) < DEPTH. Here inflight is 0 or 1
//   and count is the registered value. imem_addr=PC. On issue, PC <= PC+1 mod 2**AW:
//   address 2**AW-1 wraps to 0 with no flag. At most one read is issued per cycle.
//  Return: a read issued in cycle t delivers imem_data in cycle t+1. The word and its
//   address (held in a 1-deep in-flight register) are written to the queue tail at the
//   end of t+1. They become visible as instr_valid at t+2. No bypass from ROM to outputs.
//   Latency from issue to instr_valid is 2 cycles. Throughput is 1 instruction/cycle with
//   instr_ready held high.
//  Handshake: a pop occurs when instr_valid && instr_ready. Queue order is strict FIFO.
//   instr_data and instr_pc are stable while instr_valid=1 && instr_ready=0.
//   Push and pop may occur in the same cycle, including when the queue is full (count=DEPTH).
//   In that case count is unchanged.
//  Redirect: when Jen=1 in cycle t:
//   - the queue is emptied and count=0 at t+1;
//   - any read in flight from t-1 is squashed by an epoch bit, so its data is never enqueued;
//   - no read is issued in cycle t, and PC <= Jtarget;
//   - the first read from Jtarget is issued at t+1.
//   A pop requested in cycle t is ignored, because the flush wins.
//   Jen arriving while halted still flushes the queue and loads PC but issues nothing.
//  Halt: Halt=1 in any cycle sets the halt latch at the next edge; new issues stop from
//   that edge on. The in-flight read still completes into the queue. Decode keeps draining.
//   Done <= 1 at the first edge where the halt latch=1, queue is empty and no read is in
//   flight. Done stays 1 until Reset. Jen and Halt in the same cycle: both take effect.
//  Reset mid-operation: all state clears asynchronously. In-flight ROM data is ignored.
//   Fetch restarts from PC=0 on the first edge after Reset deasserts.
//  Arithmetic: count is a true occupancy 0..DEPTH and never exceeds DEPTH.
//   Queue pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// TESTING
//  1 Reset, then ROM data=addr and ready=1 -> imem_addr 0,1,2... on consecutive cycles.
//    instr_valid first at cycle 2 with pc=0, then one instruction per cycle in order.
//  2 ready=0 for 10 cycles -> count=4 (DEPTH=4), imem_en=0 once full.
//    Release ready -> pcs pop in order with no loss or duplication.
//  3 Jen with Jtarget=0x20 while one read is in flight and the queue is holding 3 ->
//    next valid instruction has pc=0x20, and no stale pc is delivered.
//  4 Jen with Jtarget=0x3F, ready=1 -> delivered pcs are 0x3F, 0x00, 0x01 (wrap).
//  5 Halt pulse with 2 queued and 1 in flight, ready=1 -> 3 more pops, no further
//    imem_en, Done=1 on the edge after the queue is empty. Done stays high; Halt=0 has no effect.
//  6 Reset asserted mid-stream with count=3 -> all outputs return to reset values
//    immediately, and fetch resumes from pc=0 after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, synchronous ROM read port and a
// DEPTH-entry instruction queue drained by decode over valid/ready.
module fetch_unit #(
  parameter int IW    = 9,
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Jen,
  input  logic [AW-1:0]                Jtarget,
  input  logic                         Halt,
  output logic                         imem_en,
  output logic [AW-1:0]                imem_addr,
  input  logic [IW-1:0]                imem_data,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [IW-1:0]                instr_data,
  output logic [AW-1:0]                instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         Done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_O = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH-1);

  logic [AW-1:0] pc;
  logic          halted;
  logic          done_q;
  logic          epoch;

  logic          infl_v;
  logic          infl_ep;
  logic [AW-1:0] infl_pc;

  logic [IW-1:0] q_data [DEPTH];
  logic [AW-1:0] q_pc   [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] occ;

  logic [CW:0]   pending;
  logic          issue;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // The in-flight read reserves a queue slot so a return never overflows.
  assign pending = {1'b0, occ} + {{CW{1'b0}}, infl_v};
  assign issue   = !Reset && !halted && !Jen && (pending < DEPTH_O);
  assign push    = infl_v && (infl_ep == epoch) && !Jen;
  assign pop     = (occ != '0) && instr_ready && !Jen;

  assign imem_en     = issue;
  assign imem_addr   = pc;
  assign instr_valid = (occ != '0);
  assign instr_data  = q_data[head];
  assign instr_pc    = q_pc[head];
  assign count       = occ;
  assign Done        = done_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc      <= '0;
      halted  <= 1'b0;
      done_q  <= 1'b0;
      epoch   <= 1'b0;
      infl_v  <= 1'b0;
      infl_ep <= 1'b0;
      infl_pc <= '0;
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      halted  <= halted | Halt;
      if (halted && (occ == '0) && !infl_v)
        done_q <= 1'b1;

      infl_v  <= issue;
      infl_pc <= pc;
      infl_ep <= epoch;

      if (Jen) begin
        // Flipping the epoch orphans any read still returning.
        pc    <= Jtarget;
        epoch <= ~epoch;
        head  <= '0;
        tail  <= '0;
        occ   <= '0;
      end else begin
        if (issue)
          pc <= pc + AW'(1);
        if (push) begin
          q_data[tail] <= imem_data;
          q_pc[tail]   <= infl_pc;
          tail         <= bump(tail);
        end
        if (pop)
          head <= bump(head);
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit against a transaction-level model
// built from a queue of (pc, word) entries.
module tb_fetch_unit;

  localparam int IW    = 9;
  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Jen;
  logic [AW-1:0] Jtarget;
  logic          Halt;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic [CW-1:0] count;
  logic          Done;

  always #5 Clk = ~Clk;

  fetch_unit #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Jen(Jen), .Jtarget(Jtarget),
    .Halt(Halt), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .count(count), .Done(Done)
  );

  typedef struct {
    int pc;
    int data;
  } ent_t;

  ent_t q[$];
  int   m_pc;
  bit   m_infl;
  int   m_ipc;
  bit   m_halt;
  bit   m_done;

  int checks = 0;
  int passed = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int rom(int a);
    return ((a << 3) ^ 'h0A5) & 'h1FF;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc   = 0;
    m_infl = 0;
    m_ipc  = 0;
    m_halt = 0;
    m_done = 0;
  endtask

  task automatic check_reset();
    check("rst_en",    imem_en,     0);
    check("rst_addr",  imem_addr,   0);
    check("rst_valid", instr_valid, 0);
    check("rst_data",  instr_data,  0);
    check("rst_pc",    instr_pc,    0);
    check("rst_count", count,       0);
    check("rst_done",  Done,        0);
  endtask

  task automatic cycle(bit jen, int jt, bit halt, bit rdy);
    bit en;
    bit issued;
    int a;
    @(negedge Clk);
    Reset       = 1'b0;
    Jen         = jen;
    Jtarget     = AW'(jt);
    Halt        = halt;
    instr_ready = rdy;
    #1;
    en = !m_halt && !jen && (q.size() + int'(m_infl)) < DEPTH;
    check("imem_en",   imem_en,     en);
    check("imem_addr", imem_addr,   m_pc);
    check("valid",     instr_valid, q.size() > 0);
    check("count",     count,       q.size());
    check("done",      Done,        m_done);
    if (q.size() > 0) begin
      check("head_data", instr_data, q[0].data);
      check("head_pc",   instr_pc,   q[0].pc);
    end
    if (m_halt && q.size() == 0 && !m_infl) m_done = 1;
    if (jen) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (m_infl) q.push_back('{m_ipc, rom(m_ipc)});
    end
    m_infl = en;
    m_ipc  = m_pc;
    if (jen) m_pc = jt;
    else if (en) m_pc = (m_pc + 1) % (1 << AW);
    if (halt) m_halt = 1;
    issued = imem_en;
    a      = imem_addr;
    @(posedge Clk);
    #1;
    imem_data = issued ? IW'(rom(a)) : '0;
  endtask

  // Reset is raised between edges; cycle() releases it on its next call.
  task automatic mid_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_reset();
    model_reset();
    @(posedge Clk);
    #1;
    imem_data = '0;
  endtask

  initial begin
    Reset       = 1'b1;
    Jen         = 1'b0;
    Jtarget     = '0;
    Halt        = 1'b0;
    instr_ready = 1'b0;
    imem_data   = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset();

    repeat (12) cycle(0, 0, 0, 1);
    repeat (10) cycle(0, 0, 0, 0);
    repeat (8)  cycle(0, 0, 0, 1);

    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 'h20, 0, 1);
    repeat (6) cycle(0, 0, 0, 1);

    cycle(1, 'h3F, 0, 1);
    repeat (6) cycle(0, 0, 0, 1);

    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 1);
    repeat (8) cycle(0, 0, 0, 1);
    cycle(1, 5, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);

    mid_reset();
    repeat (4) cycle(0, 0, 0, 0);
    mid_reset();
    repeat (6) cycle(0, 0, 0, 1);

    repeat (10) begin
      mid_reset();
      repeat (60) begin
        bit jen;
        bit hlt;
        bit rdy;
        int jt;
        jen = ($urandom_range(0, 7) == 0);
        hlt = ($urandom_range(0, 49) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        jt  = ($urandom_range(0, 3) == 0) ? 'h3F : $urandom_range(0, 63);
        cycle(jen, jt, hlt, rdy);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
